// File: rtl/sbox_share_sched_if.sv
// Per-requester channel for sbox_share_sched: a request leg carrying the 48-bit block
// and a response leg returning the 32-bit substitution result.
interface sbox_share_sched_if;
    logic        req_valid;
    logic        req_ready;
    logic [47:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sbox_share_sched.sv
// Time-shares one combinational 8-way S-box port between two requesters, round-robin,
// walking the eight 6-bit chunks (S1 first) over eight cycles per block.
module sbox_share_sched (
    input  logic                      clk,
    input  logic                      rst_n,
    sbox_share_sched_if.slave         port0,
    sbox_share_sched_if.slave         port1,
    output logic [2:0]                sbox_sel,
    output logic [5:0]                sbox_in,
    input  logic [3:0]                sbox_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg;
    logic        prio_reg;
    logic        owner_reg;
    logic [47:0] data_reg;
    logic [31:0] result_reg, result_next;

    logic        grant0, grant1;
    logic        accept;
    logic        rsp_fire;
    logic [5:0]  chunk [8];

    // A lone requester always wins; on contention prio_reg picks the winner.
    assign grant0   = port0.req_valid & (~port1.req_valid | ~prio_reg);
    assign grant1   = port1.req_valid & (~port0.req_valid |  prio_reg);
    assign accept   = (state_reg == IDLE) & (grant0 | grant1);
    assign rsp_fire = (state_reg == DONE) & (owner_reg ? port1.rsp_ready : port0.rsp_ready);

    // Chunk gi feeds S-box gi; its 4-bit result lands in nibble gi counted from the MSB.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_chunk
            assign chunk[gi] = data_reg[47-6*gi -: 6];
            assign result_next[31-4*gi -: 4] =
                ((state_reg == RUN) && (cnt_reg == 3'(gi))) ? sbox_out
                                                            : result_reg[31-4*gi -: 4];
        end
    endgenerate

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= 3'd0;
            prio_reg   <= 1'b0;
            owner_reg  <= 1'b0;
            data_reg   <= 48'd0;
            result_reg <= 32'd0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            if (accept) begin
                cnt_reg   <= 3'd0;
                owner_reg <= grant1;
                prio_reg  <= ~grant1;
                data_reg  <= grant1 ? port1.req_data : port0.req_data;
            end else if (state_reg == RUN) begin
                cnt_reg <= cnt_reg + 3'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)            state_next = RUN;
            RUN:     if (cnt_reg == 3'd7)   state_next = DONE;
            DONE:    if (rsp_fire)          state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        port0.req_ready = 1'b0;
        port1.req_ready = 1'b0;
        port0.rsp_valid = 1'b0;
        port1.rsp_valid = 1'b0;
        sbox_sel        = 3'd0;
        sbox_in         = 6'd0;
        case (state_reg)
            IDLE: begin
                port0.req_ready = grant0;
                port1.req_ready = grant1;
            end
            RUN: begin
                sbox_sel = cnt_reg;
                sbox_in  = chunk[cnt_reg];
            end
            DONE: begin
                port0.rsp_valid = ~owner_reg;
                port1.rsp_valid =  owner_reg;
            end
            default: ;
        endcase
    end

    // Both responders see the same register; only the valid one is meaningful.
    assign port0.rsp_data = result_reg;
    assign port1.rsp_data = result_reg;

endmodule

// File: doc/sbox_share_sched.md
# sbox_share_sched

Scheduler that time-shares a single S-box lookup port between two requesters, such as two DES stages of the Triple-DES pipeline. Each request carries one 48-bit post-expansion/key-XOR block. The block arbitrates round-robin and walks the eight 6-bit chunks through the shared lookup over eight cycles, S1 first. It assembles the 32-bit substitution result and returns it to the winning requester over a valid/ready handshake. The shared lookup is a purely combinational 8-way S-box selected by index.

## Interface
- none: the block is fixed at 2 requesters and 8 S-boxes.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a block
- req0_ready  out  1  requester 0 block accepted this cycle
- req0_data  in  48  requester 0 block, bits [47:42] go to S1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_data  out  32  result, S1 output in [31:28]
- req1_valid, req1_ready, req1_data, rsp1_valid, rsp1_ready, rsp1_data: same as requester 0
- sbox_sel  out  3  S-box index, 0 = S1 … 7 = S8
- sbox_in  out  6  6-bit lookup input
- sbox_out  in  4  combinational lookup result for sbox_sel/sbox_in

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- The round-robin pointer `prio` is 1 bit. Reset value is 0, which favours requester 0.
- IDLE, grant rules:
  - The grant goes to the only valid requester.
  - If both are valid, the grant goes to requester `prio`.
- reqN_ready = (state==IDLE) & reqN_valid & granted. It is combinational from the valids.
- On accept (valid & ready):
  - Latch the data and record the owner.
  - Set prio = ~owner.
  - Clear cnt to 0 and go to RUN.
- RUN, per cycle:
  - sbox_sel = cnt.
  - sbox_in = data[47-6*cnt -: 6].
  - At the clock edge, sbox_out is written to result[31-4*cnt -: 4].
  - cnt increments. After cnt = 7, go to DONE.
- DONE:
  - rsp<owner>_valid = 1. The other rsp valid stays 0.
  - rsp_data is held stable while valid.
  - When rsp<owner>_ready = 1, go to IDLE. No request is accepted in that same cycle.
- In IDLE and DONE, sbox_sel and sbox_in are driven 0.
- rsp0_data and rsp1_data both drive the result register. Only the valid one is meaningful.
- A requester may drop valid before acceptance. Nothing is recorded in that case.
- reqN_data only has to be stable in the accept cycle.
- Reset mid-operation:
  - The operation in flight is aborted with no response.
  - State returns to IDLE, prio to 0, and result to 0.

## Timing
- Reset values:
  - req*_ready = 0, rsp*_valid = 0, rsp*_data = 0.
  - sbox_sel = 0, sbox_in = 0.
  - state = IDLE, cnt = 0.
- Latency: accept in cycle T, RUN occupies T+1..T+8, and rspN_valid is high from T+9.
- If rsp_ready is held high, rsp_valid lasts exactly one cycle (T+9). The earliest next accept is T+10.
- Peak throughput is one block per 10 cycles.
- Backpressure: the block stays in DONE indefinitely while rsp_ready = 0. Both req_ready stay 0 during that time.
- Simultaneous valids in IDLE: exactly one ready is asserted. Under continuous contention, grants alternate 0,1,0,1,… starting with requester 0 after reset.
- rspN_ready asserted while rspN_valid = 0 is ignored.

## Test plan
- Single request, functional result:
  - Stimulus: req0 with data 48'h0; bench drives sbox_out from a DES S-box model.
  - Required: rsp0_data = 32'hEFA72C4D at T+9; rsp1_valid stays 0.
- All-ones data, ordering check:
  - Stimulus: req1 with data 48'hFFFF_FFFF_FFFF.
  - Required: rsp1_data = 32'hD9CE3DCB.
  - Required: sbox_sel steps 0..7 on T+1..T+8, with sbox_in = 6'h3F on every step.
- Contention:
  - Stimulus: both requesters held valid continuously, rsp_ready = 1.
  - Required: grants alternate 0,1,0,1; accepts land exactly 10 cycles apart; each response carries its own requester's data.
- Backpressure:
  - Stimulus: rsp0_ready held 0 for 5 cycles after rsp0_valid.
  - Required: rsp0_valid and rsp0_data stay stable; req1_ready stays 0 even with req1_valid = 1; req1 is accepted the cycle after the handshake completes.
- Reset mid-RUN:
  - Stimulus: assert rst_n = 0 with cnt = 4.
  - Required: all outputs go to 0 immediately with no response; after release, a new req0 completes normally and prio = 0.
- Valid withdrawal:
  - Stimulus: req0_valid pulses in a cycle where req1 is granted.
  - Required: req0 is not accepted; only req1's response appears.
